ps2_host_tx: RTL and testbench

PS/2 host-to-device transmitter. It sends one command byte to the mouse, for example 0xF4 "enable data reporting" or 0xFF "reset". It runs in the 100 MHz mouse clock domain alongside the existing PS/2 receive path and drives the bidirectional ps2_clk/ps2_data pins through open-drain enables. It generates the inhibit and request-to-send sequence, shifts out data, parity and stop on device clock edges, checks the device ACK, and reports done or error.

---
 rtl/ps2_host_tx_if.sv | 26 ++
 rtl/ps2_host_tx.sv | 211 +++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_host_tx_if.sv
// Command-side handshake between a PS/2 host controller and the transmitter.
// The master issues a byte with a one-cycle tx_start; the slave (transmitter)
// reports busy and pulses done or err once the frame completes.
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       busy;
    logic       done;
    logic       err;

    modport master (
        output tx_data,
        output tx_start,
        input  busy,
        input  done,
        input  err
    );

    modport slave (
        input  tx_data,
        input  tx_start,
        output busy,
        output done,
        output err
    );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter.
// Pulls ps2_clk low to inhibit the device, asserts the start bit as a
// request-to-send, then shifts data, odd parity and stop out on device clock
// falling edges and checks the device ACK. Both pins are open-drain: an oe
// of 1 pulls the line low, 0 releases it.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | lines released, waiting for tx_start
// INHIBIT    | ps2_clk held low; start bit asserted in the final cycle
// RTS        | clk released, start bit held, waiting for first device fall
// SHIFT      | presenting data/parity/stop, one bit per device fall
// ACK        | stop presented, sampling ps2_data on the 11th fall
// WAIT_REL   | ACK seen, waiting for device to release clk and data
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 12000,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int FILTER_LEN     = 8
) (
    input  logic         clk,
    input  logic         rst,
    ps2_host_tx_if.slave bus,
    input  logic         ps2_clk_in,
    input  logic         ps2_data_in,
    output logic         ps2_clk_oe,
    output logic         ps2_data_oe
);

    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int FLT_W = $clog2(FILTER_LEN + 1);

    // INHIBIT_CYCLES must be at least 2 so the start bit lands in the last
    // inhibit cycle rather than alongside the clock pull.
    localparam logic [INH_W-1:0] INH_PRE  = INH_W'(INHIBIT_CYCLES - 2);
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(FILTER_LEN - 1);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_INHIBIT  = 3'd1;
    localparam logic [2:0] ST_RTS      = 3'd2;
    localparam logic [2:0] ST_SHIFT    = 3'd3;
    localparam logic [2:0] ST_ACK      = 3'd4;
    localparam logic [2:0] ST_WAIT_REL = 3'd5;

    logic             clk_meta;
    logic             clk_sync;
    logic             data_meta;
    logic             data_sync;
    logic             clk_filt;
    logic [FLT_W-1:0] filt_cnt;
    logic             fall;

    logic [2:0]       state;
    logic [9:0]       shift;
    logic [3:0]       bit_cnt;
    logic [INH_W-1:0] inh_cnt;
    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_hit;
    logic             busy_q;
    logic             done_q;
    logic             err_q;

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.err  = err_q;

    assign tmo_hit = (tmo_cnt == TMO_LAST);

    // Two-stage synchronizers; idle bus level is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_meta  <= 1'b1;
            clk_sync  <= 1'b1;
            data_meta <= 1'b1;
            data_sync <= 1'b1;
        end else begin
            clk_meta  <= ps2_clk_in;
            clk_sync  <= clk_meta;
            data_meta <= ps2_data_in;
            data_sync <= data_meta;
        end
    end

    // Glitch filter on ps2_clk: a new level needs FILTER_LEN equal samples;
    // a 1->0 acceptance emits a single-cycle fall strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_filt <= 1'b1;
            filt_cnt <= '0;
            fall     <= 1'b0;
        end else begin
            fall <= 1'b0;
            if (clk_sync == clk_filt) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FLT_LAST) begin
                clk_filt <= clk_sync;
                filt_cnt <= '0;
                fall     <= clk_filt;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    // Transmit sequencer: inhibit, request-to-send, shift, ACK and release,
    // with a watchdog restarted on every state entry and every device fall.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            shift       <= '0;
            bit_cnt     <= '0;
            inh_cnt     <= '0;
            tmo_cnt     <= '0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.tx_start) begin
                        shift      <= {1'b1, ~^bus.tx_data, bus.tx_data};
                        inh_cnt    <= '0;
                        ps2_clk_oe <= 1'b1;
                        busy_q     <= 1'b1;
                        state      <= ST_INHIBIT;
                    end
                end

                ST_INHIBIT: begin
                    inh_cnt <= inh_cnt + 1'b1;
                    if (inh_cnt == INH_PRE) begin
                        ps2_data_oe <= 1'b1;
                    end
                    if (inh_cnt == INH_LAST) begin
                        ps2_clk_oe <= 1'b0;
                        bit_cnt    <= '0;
                        tmo_cnt    <= '0;
                        state      <= ST_RTS;
                    end
                end

                ST_RTS, ST_SHIFT: begin
                    if (fall) begin
                        // The 10th fall presents the stop bit; the 11th is the ACK.
                        ps2_data_oe <= ~shift[0];
                        shift       <= {1'b0, shift[9:1]};
                        bit_cnt     <= bit_cnt + 1'b1;
                        tmo_cnt     <= '0;
                        state       <= (bit_cnt == 4'd9) ? ST_ACK : ST_SHIFT;
                    end else if (tmo_hit) begin
                        ps2_data_oe <= 1'b0;
                        busy_q      <= 1'b0;
                        err_q       <= 1'b1;
                        state       <= ST_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end

                ST_ACK: begin
                    if (fall) begin
                        tmo_cnt <= '0;
                        if (!data_sync) begin
                            state <= ST_WAIT_REL;
                        end else begin
                            busy_q <= 1'b0;
                            err_q  <= 1'b1;
                            state  <= ST_IDLE;
                        end
                    end else if (tmo_hit) begin
                        ps2_data_oe <= 1'b0;
                        busy_q      <= 1'b0;
                        err_q       <= 1'b1;
                        state       <= ST_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end

                ST_WAIT_REL: begin
                    if (clk_filt && data_sync) begin
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= ST_IDLE;
                    end else if (tmo_hit) begin
                        ps2_data_oe <= 1'b0;
                        busy_q      <= 1'b0;
                        err_q       <= 1'b1;
                        state       <= ST_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end

                default: begin
                    ps2_clk_oe  <= 1'b0;
                    ps2_data_oe <= 1'b0;
                    busy_q      <= 1'b0;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 device drives the open-drain
// lines, samples each host bit on its clock rising edge and ACKs (or not).
// Inhibit is shortened to keep the run short; timeout is 5000 cycles.
module tb_ps2_host_tx;
    localparam int INH = 600;
    localparam int TMO = 5000;
    localparam int FLT = 8;
    localparam int H   = 40;

    logic clk      = 1'b0;
    logic rst      = 1'b1;
    logic dev_clk  = 1'b1;
    logic dev_data = 1'b1;
    logic ps2_clk_oe;
    logic ps2_data_oe;
    logic ps2_clk_in;
    logic ps2_data_in;

    int errors        = 0;
    int checks        = 0;
    int done_cnt      = 0;
    int err_cnt       = 0;
    int overlap_cnt   = 0;
    int done_busy_cnt = 0;

    ps2_host_tx_if bus ();

    assign ps2_clk_in  = dev_clk  & ~ps2_clk_oe;
    assign ps2_data_in = dev_data & ~ps2_data_oe;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TMO),
        .FILTER_LEN    (FLT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .ps2_clk_in (ps2_clk_in),
        .ps2_data_in(ps2_data_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.done) begin
            done_cnt++;
            if (bus.busy) done_busy_cnt++;
        end
        if (bus.err) err_cnt++;
        if (bus.done && bus.err) overlap_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Line levels the device should see: start, data LSB first, odd parity, stop.
    function automatic logic [10:0] exp_frame(input logic [7:0] b);
        logic [10:0] f;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = b[i];
        f[9]  = (($countones(b) % 2) == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    task automatic start_and_inhibit(input logic [7:0] b);
        int n;
        int first_data;
        bus.tx_data  = b;
        bus.tx_start = 1'b1;
        tick(1);
        bus.tx_start = 1'b0;
        bus.tx_data  = 8'($urandom);
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_start: got %b want 1", bus.busy);
        end
        n = 0;
        first_data = -1;
        while (ps2_clk_oe === 1'b1 && n < INH + 100) begin
            if (ps2_data_oe === 1'b1 && first_data < 0) first_data = n;
            n++;
            tick(1);
        end
        checks++;
        if (n != INH) begin
            errors++;
            $display("FAIL inhibit_len: got %0d want %0d", n, INH);
        end
        checks++;
        if (first_data != INH - 1) begin
            errors++;
            $display("FAIL start_bit_cycle: got %0d want %0d", first_data, INH - 1);
        end
        checks++;
        if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b1) begin
            errors++;
            $display("FAIL rts_lines: got clk_oe=%b data_oe=%b want 0/1", ps2_clk_oe, ps2_data_oe);
        end
    endtask

    task automatic dev_run(input int nfalls, input bit ack, input bit glitch,
                           output logic [10:0] seen, output int stab_bad);
        logic oe_rise;
        seen     = '1;
        stab_bad = 0;
        tick(20);
        seen[0] = ps2_data_in;
        for (int k = 1; k <= nfalls; k++) begin
            dev_clk = 1'b0;
            tick(H);
            dev_clk = 1'b1;
            if (k <= 10) seen[k] = ps2_data_in;
            if (k == 10 && ack) dev_data = 1'b0;
            if (k == 11) dev_data = 1'b1;
            oe_rise = ps2_data_oe;
            for (int t = 0; t < H; t++) begin
                if (glitch && k == 3 && t == 20) dev_clk = 1'b0;
                if (glitch && k == 3 && t == 24) dev_clk = 1'b1;
                tick(1);
                if (ps2_data_oe !== oe_rise) stab_bad++;
            end
        end
    endtask

    task automatic full_transfer(input logic [7:0] b, input bit glitch, output logic [10:0] seen);
        int d0, e0, db0, sb;
        start_and_inhibit(b);
        d0 = done_cnt; e0 = err_cnt; db0 = done_busy_cnt;
        dev_run(11, 1'b1, glitch, seen, sb);
        tick(20);
        checks++;
        if (seen !== exp_frame(b)) begin
            errors++;
            $display("FAIL frame_%02h: got %b want %b", b, seen, exp_frame(b));
        end
        checks++;
        if (sb != 0) begin
            errors++;
            $display("FAIL data_stable_%02h: got %0d changes while clk high want 0", b, sb);
        end
        checks++;
        if (done_cnt - d0 != 1 || err_cnt - e0 != 0) begin
            errors++;
            $display("FAIL pulses_%02h: got done=%0d err=%0d want 1/0", b, done_cnt - d0, err_cnt - e0);
        end
        checks++;
        if (done_busy_cnt != db0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_at_done_%02h: got busy-in-done=%0d busy=%b want 0/0",
                     b, done_busy_cnt - db0, bus.busy);
        end
    endtask

    task automatic test_reset();
        tick(1);
        checks++;
        if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0 || bus.busy !== 1'b0 ||
            bus.done !== 1'b0 || bus.err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got clk_oe=%b data_oe=%b busy=%b done=%b err=%b want 0",
                     ps2_clk_oe, ps2_data_oe, bus.busy, bus.done, bus.err);
        end
        rst = 1'b0;
        tick(5);
        checks++;
        if (ps2_clk_oe !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got clk_oe=%b busy=%b want 0/0", ps2_clk_oe, bus.busy);
        end
    endtask

    task automatic test_f4();
        logic [10:0] seen;
        full_transfer(8'hF4, 1'b0, seen);
    endtask

    task automatic test_zero_parity();
        logic [10:0] seen;
        full_transfer(8'h00, 1'b0, seen);
        checks++;
        if (seen[9] !== 1'b1 || seen[10] !== 1'b1) begin
            errors++;
            $display("FAIL parity_zero: got parity=%b stop=%b want 1/1", seen[9], seen[10]);
        end
    endtask

    task automatic test_random_bytes();
        logic [10:0] seen;
        for (int i = 0; i < 6; i++) begin
            full_transfer(8'($urandom), (i % 3) == 0, seen);
            tick($urandom_range(0, 30));
        end
    endtask

    task automatic test_nack();
        logic [10:0] seen;
        logic [7:0]  b;
        int d0, e0, sb;
        b = 8'($urandom);
        start_and_inhibit(b);
        d0 = done_cnt; e0 = err_cnt;
        dev_run(11, 1'b0, 1'b0, seen, sb);
        checks++;
        if (err_cnt - e0 != 1 || done_cnt - d0 != 0) begin
            errors++;
            $display("FAIL nack_pulses: got err=%0d done=%0d want 1/0", err_cnt - e0, done_cnt - d0);
        end
        checks++;
        if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL nack_lines: got clk_oe=%b data_oe=%b busy=%b want 0",
                     ps2_clk_oe, ps2_data_oe, bus.busy);
        end
        checks++;
        if (seen !== exp_frame(b)) begin
            errors++;
            $display("FAIL nack_frame: got %b want %b", seen, exp_frame(b));
        end
    endtask

    task automatic test_timeout();
        int n, e0, d0;
        e0 = err_cnt; d0 = done_cnt;
        start_and_inhibit(8'h5A);
        n = 0;
        while (bus.err !== 1'b1 && n < TMO + 100) begin
            tick(1);
            n++;
        end
        checks++;
        if (n != TMO) begin
            errors++;
            $display("FAIL timeout_cycles: got %0d want %0d", n, TMO);
        end
        checks++;
        if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_lines: got clk_oe=%b data_oe=%b busy=%b want 0",
                     ps2_clk_oe, ps2_data_oe, bus.busy);
        end
        tick(5);
        checks++;
        if (err_cnt - e0 != 1 || done_cnt - d0 != 0) begin
            errors++;
            $display("FAIL timeout_pulses: got err=%0d done=%0d want 1/0", err_cnt - e0, done_cnt - d0);
        end
    endtask

    task automatic test_ignore_start();
        logic [10:0] seen;
        int d0, e0, sb;
        start_and_inhibit(8'hF4);
        d0 = done_cnt; e0 = err_cnt;
        tick(3);
        bus.tx_data  = 8'hFF;
        bus.tx_start = 1'b1;
        tick(1);
        bus.tx_start = 1'b0;
        dev_run(11, 1'b1, 1'b0, seen, sb);
        tick(40);
        checks++;
        if (seen !== exp_frame(8'hF4)) begin
            errors++;
            $display("FAIL ignore_frame: got %b want %b", seen, exp_frame(8'hF4));
        end
        checks++;
        if (done_cnt - d0 != 1 || err_cnt - e0 != 0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL ignore_pulses: got done=%0d err=%0d busy=%b want 1/0/0",
                     done_cnt - d0, err_cnt - e0, bus.busy);
        end
    endtask

    task automatic test_reset_mid();
        logic [10:0] seen;
        logic [10:0] ef;
        logic [7:0]  b;
        int d0, e0, sb;
        b  = 8'($urandom);
        ef = exp_frame(b);
        start_and_inhibit(b);
        d0 = done_cnt; e0 = err_cnt;
        dev_run(5, 1'b0, 1'b0, seen, sb);
        rst = 1'b1;
        tick(1);
        checks++;
        if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_lines: got clk_oe=%b data_oe=%b busy=%b want 0",
                     ps2_clk_oe, ps2_data_oe, bus.busy);
        end
        rst = 1'b0;
        tick(200);
        checks++;
        if (done_cnt != d0 || err_cnt != e0) begin
            errors++;
            $display("FAIL rst_mid_pulses: got done=%0d err=%0d want 0/0", done_cnt - d0, err_cnt - e0);
        end
        checks++;
        if (seen[4:0] !== ef[4:0]) begin
            errors++;
            $display("FAIL rst_mid_bits: got %b want %b", seen[4:0], ef[4:0]);
        end
    endtask

    task automatic test_invariants();
        checks++;
        if (overlap_cnt != 0) begin
            errors++;
            $display("FAIL done_err_overlap: got %0d cycles want 0", overlap_cnt);
        end
    endtask

    initial begin
        bus.tx_start = 1'b0;
        bus.tx_data  = 8'h00;
        tick(4);
        test_reset();
        test_f4();
        test_zero_parity();
        test_random_bytes();
        test_nack();
        test_timeout();
        test_ignore_start();
        test_reset_mid();
        test_f4();
        test_invariants();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
